ssd_scan_driver: RTL and testbench

- Parametrised time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus.
- Latches a packed hex value into a shadow register and scans one digit at a time at a programmable refresh rate.
- Adds per-digit decimal points, leading-zero blanking, a global enable and selectable output polarity.
- Sits between the CPU debug/register-view path and the board display pins.

---
 rtl/ssd_scan_driver.sv | 123 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver: shadow-latched hex value, per-digit dp,
// leading-zero blanking, scan enable and selectable output polarity.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;
    logic [CNT_W-1:0]        cnt;

    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    all_zero;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              seg_on_c;
    logic                    dp_on_c;
    logic [NUM_DIGITS-1:0]   an_on_c;

    // Active-low segment patterns, bit6 = g ... bit0 = a.
    function automatic logic [6:0] decode_low(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    // Next output values in asserted-high form; polarity is applied at the register.
    always_comb begin
        zero_from = '0;
        all_zero  = 1'b1;
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_on_c   = '0;
        seg_on_c  = 7'h00;
        dp_on_c   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (shadow[4*i +: 4] == 4'h0);
            zero_from[i] = all_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_digit  = shadow[4*i +: 4];
                cur_dp     = dp_shadow[i];
                cur_blank  = (i > 0) && blank_lz && zero_from[i];
                an_on_c[i] = 1'b1;
            end
        end
        if (enable) begin
            dp_on_c  = cur_dp;
            seg_on_c = cur_blank ? 7'h00 : ~decode_low(cur_digit);
        end else begin
            an_on_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= '0;
            dp_shadow <= '0;
            cnt       <= '0;
            digit_idx <= '0;
            seg_out   <= SEG_POL;
            dp_out    <= ACTIVE_LOW;
            an_out    <= AN_POL;
        end else begin
            if (load) begin
                shadow    <= value;
                dp_shadow <= dp_in;
            end
            if (enable) begin
                if (cnt == CNT_MAX) begin
                    cnt       <= '0;
                    digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            seg_out <= seg_on_c ^ SEG_POL;
            dp_out  <= dp_on_c ^ ACTIVE_LOW;
            an_out  <= an_on_c ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: active-low and active-high instances share stimulus and
// are checked every cycle against a queued behavioural model plus directed checks.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        reset, load, enable, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0]  seg_lo, seg_hi;
    logic        dp_lo, dp_hi;
    logic [3:0]  an_lo, an_hi;
    logic [1:0]  idx_lo, idx_hi;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .enable(enable), .blank_lz(blank_lz), .seg_out(seg_lo), .dp_out(dp_lo),
        .an_out(an_lo), .digit_idx(idx_lo));

    ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .enable(enable), .blank_lz(blank_lz), .seg_out(seg_hi), .dp_out(dp_hi),
        .an_out(an_hi), .digit_idx(idx_hi));

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Expected outputs in asserted-high form.
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
    } exp_t;

    exp_t sb [$];

    logic [15:0] m_shadow = '0;
    logic [3:0]  m_dp     = '0;
    int          m_cnt    = 0;
    int          m_idx    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict this edge, advance the model, then compare once outputs settle.
    task automatic cycle();
        exp_t       e;
        logic [3:0] d;
        logic       blank;
        logic [6:0] lo_seg;
        logic [3:0] lo_an;
        logic       lo_dp;
        e = '0;
        if (!reset && enable) begin
            d        = m_shadow[m_idx*4 +: 4];
            blank    = blank_lz && (m_idx > 0) && ((m_shadow >> (m_idx*4)) == 16'h0);
            e.an     = 4'b0001 << m_idx;
            e.dp     = m_dp[m_idx];
            e.seg    = blank ? 7'h00 : ~seg_tbl[d];
        end
        if (reset) begin
            m_shadow = '0; m_dp = '0; m_cnt = 0; m_idx = 0;
        end else begin
            if (load) begin
                m_shadow = value; m_dp = dp_in;
            end
            if (enable) begin
                if (m_cnt == 3) begin
                    m_cnt = 0; m_idx = (m_idx + 1) % 4;
                end else begin
                    m_cnt++;
                end
            end
        end
        e.idx = 2'(m_idx);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        lo_seg = ~e.seg; lo_an = ~e.an; lo_dp = ~e.dp;
        chk("sb_seg_lo", seg_lo, lo_seg);
        chk("sb_an_lo",  an_lo,  lo_an);
        chk("sb_dp_lo",  dp_lo,  lo_dp);
        chk("sb_idx_lo", idx_lo, e.idx);
        chk("sb_seg_hi", seg_hi, e.seg);
        chk("sb_an_hi",  an_hi,  e.an);
        chk("sb_dp_hi",  dp_hi,  e.dp);
        chk("sb_idx_hi", idx_hi, e.idx);
    endtask

    // Run n cycles checking seg_lo against per-digit patterns of whichever anode is lit.
    task automatic scan_check(input string tag, input logic [27:0] segs, input int n);
        logic [3:0] m;
        for (int c = 0; c < n; c++) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                m = ~(4'b0001 << i);
                if (an_lo == m) chk(tag, seg_lo, segs[7*i +: 7]);
            end
        end
    endtask

    task automatic wait_cnt(input int target);
        int k;
        for (k = 0; k < 8 && m_cnt != target; k++) cycle();
        if (m_cnt != target) begin
            n_fail++;
            $display("FAIL wait_cnt: model counter %0d target %0d", m_cnt, target);
        end
    endtask

    initial begin
        logic [27:0] segs;
        logic [15:0] nv;
        logic [1:0]  held;
        logic        exp_dp;
        logic [3:0]  exp_an;

        reset = 1'b1; load = 1'b0; enable = 1'b0; blank_lz = 1'b0;
        value = '0; dp_in = '0;
        cycle(); cycle();
        chk("rst_seg_lo", seg_lo, 7'h7F);
        chk("rst_an_lo",  an_lo,  4'hF);
        chk("rst_dp_lo",  dp_lo,  1'b1);
        chk("rst_seg_hi", seg_hi, 7'h00);
        chk("rst_idx",    idx_lo, 2'd0);

        // Scan order with 12AF.
        reset = 1'b0; value = 16'h12AF; load = 1'b1;
        cycle();
        load = 1'b0; enable = 1'b1;
        segs = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
        for (int dg = 0; dg < 4; dg++) begin
            cycle();
            exp_an = ~(4'b0001 << dg);
            chk("scan_seg", seg_lo, segs[7*dg +: 7]);
            chk("scan_an",  an_lo,  exp_an);
            cycle(); cycle(); cycle();
        end
        cycle();
        chk("scan_wrap_an", an_lo, 4'b1110);

        // Leading-zero blanking.
        blank_lz = 1'b1; value = 16'h0050; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        scan_check("lz_0050", {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 16);
        value = 16'h0000; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        scan_check("lz_0000", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 16);
        blank_lz = 1'b0;

        // Load on the tick cycle, then value changes with load low.
        wait_cnt(3);
        nv = 16'h3456; value = nv; load = 1'b1;
        cycle();
        load = 1'b0; value = 16'h8888;
        cycle();
        chk("tick_load_seg", seg_lo, seg_tbl[nv[m_idx*4 +: 4]]);
        exp_an = ~(4'b0001 << m_idx);
        chk("tick_load_an", an_lo, exp_an);
        scan_check("no_load", {seg_tbl[3], seg_tbl[4], seg_tbl[5], seg_tbl[6]}, 12);

        // Decimal point and enable freeze.
        dp_in = 4'b0100; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_cnt(1);
        enable = 1'b0;
        cycle();
        chk("dis_an",  an_lo,  4'hF);
        chk("dis_seg", seg_lo, 7'h7F);
        chk("dis_dp",  dp_lo,  1'b1);
        held = idx_lo;
        cycle(); cycle();
        chk("dis_idx_hold", idx_lo, held);
        enable = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            exp_dp = (an_lo != 4'b1011);
            chk("dp_digit2", dp_lo, exp_dp);
        end

        // Active-high polarity and mid-scan reset.
        value = 16'h8888; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle(); cycle();
        chk("hi_seg8", seg_hi, 7'h7F);
        chk("hi_an_onehot", $countones(an_hi), 1);
        wait_cnt(2);
        reset = 1'b1;
        cycle();
        chk("rst_mid_an_hi",  an_hi,  4'h0);
        chk("rst_mid_seg_hi", seg_hi, 7'h00);
        chk("rst_mid_idx",    idx_hi, 2'd0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
